// File: rtl/bch_pkg.sv
// Shared definitions for the BCH(63,56) encoder and syndrome path.
// g(x) = x^7 + x^6 + x^2 + 1; BCH_GPOLY holds the low coefficients, x^7 implicit.
// Optional feature macro used by the encoder: BCH_ENC_SERIAL_OUT_EN.
package bch_pkg;

  localparam int BCH_N = 63;
  localparam int BCH_K = 56;
  localparam int BCH_P = 7;

  localparam logic [BCH_P-1:0] BCH_GPOLY = 7'h45;

  // Bit counter width: must hold BCH_K-1 (55).
  localparam int BCH_CNT_W = 6;

  // Encoder control states. PARITY is only visited when serial output is built in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } bch_state_t;

endpackage

// File: rtl/bch_lfsr_step.sv
// One clock's worth of division by g(x): takes the current remainder and the
// next message bit, returns the updated remainder. Purely combinational so the
// syndrome path can reuse it with the received bit as d.
module bch_lfsr_step
  import bch_pkg::*;
(
  input  logic [BCH_P-1:0] lfsr,
  input  logic             d,
  output logic [BCH_P-1:0] lfsr_next
);

  // Feedback is the incoming bit plus the coefficient leaving the x^6 stage.
  logic fb;

  assign fb        = d ^ lfsr[BCH_P-1];
  assign lfsr_next = {lfsr[BCH_P-2:0], 1'b0} ^ ({BCH_P{fb}} & BCH_GPOLY);

endmodule

// File: rtl/bch_encoder.sv
// Systematic serial BCH(63,56) encoder. The 56 message bits are clocked,
// MSB first, through a 7-bit remainder register; the result is presented as
// codeword = {msg, parity} with a one-cycle done pulse.
// Optional serial output: define BCH_ENC_SERIAL_OUT_EN to add ser_bit/ser_valid
// and a PARITY phase that streams the 7 parity bits after the message bits.
//
// Handshake: start is only looked at while the FSM is IDLE (busy=0 and not in
// the done cycle); there is no queueing. busy rises on the edge that accepts
// start and falls on the edge that raises done. done is high for exactly one
// cycle and codeword is valid from that cycle until the next done.
module bch_encoder
  import bch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BCH_K-1:0] msg,
  output logic             busy,
  output logic             done,
  output logic [BCH_N-1:0] codeword,
`ifdef BCH_ENC_SERIAL_OUT_EN
  output logic             ser_bit,
  output logic             ser_valid,
`endif
  output bch_state_t       dbg_state
);

  bch_state_t             state;
  logic [BCH_K-1:0]       msg_q;
  logic [BCH_P-1:0]       lfsr;
  logic [BCH_P-1:0]       lfsr_next;
  logic [BCH_CNT_W-1:0]   cnt;
  logic                   d;

  // Current message bit: cnt walks from BCH_K-1 down to 0, so msg[55] goes first.
  assign d         = msg_q[cnt];
  assign dbg_state = state;

  bch_lfsr_step u_step (
    .lfsr      (lfsr),
    .d         (d),
    .lfsr_next (lfsr_next)
  );

  // Control FSM, remainder register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      msg_q     <= '0;
      lfsr      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      codeword  <= '0;
`ifdef BCH_ENC_SERIAL_OUT_EN
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
`ifdef BCH_ENC_SERIAL_OUT_EN
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            msg_q <= msg;
            lfsr  <= '0;
            cnt   <= BCH_CNT_W'(BCH_K - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          lfsr <= lfsr_next;
`ifdef BCH_ENC_SERIAL_OUT_EN
          ser_bit   <= d;
          ser_valid <= 1'b1;
`endif
          if (cnt == '0) begin
`ifdef BCH_ENC_SERIAL_OUT_EN
            // Remainder is final; reuse cnt to index parity bits 6..0.
            cnt   <= BCH_CNT_W'(BCH_P - 1);
            state <= PARITY;
`else
            codeword <= {msg_q, lfsr_next};
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef BCH_ENC_SERIAL_OUT_EN
        PARITY: begin
          // lfsr is left untouched so the parallel codeword can still use it.
          ser_bit   <= lfsr[cnt[2:0]];
          ser_valid <= 1'b1;
          if (cnt == '0) begin
            codeword <= {msg_q, lfsr};
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        DONE: begin
          // start is deliberately not sampled here.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder (default build and BCH_ENC_SERIAL_OUT_EN).
module tb_bch_encoder;
  import bch_pkg::*;

`ifdef BCH_ENC_SERIAL_OUT_EN
  localparam int LAT = 63;
`else
  localparam int LAT = 56;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [55:0] msg;
  logic        busy;
  logic        done;
  logic [62:0] codeword;
  bch_state_t  dbg_state;
`ifdef BCH_ENC_SERIAL_OUT_EN
  logic        ser_bit;
  logic        ser_valid;
`endif

  logic [62:0] exp_q[$];
  int          n_vec;
  int          n_err;

  bch_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .msg       (msg),
    .busy      (busy),
    .done      (done),
    .codeword  (codeword),
`ifdef BCH_ENC_SERIAL_OUT_EN
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of v(x) modulo g(x) = x^7+x^6+x^2+1 by long division.
  function automatic logic [6:0] rem63(input logic [62:0] v);
    logic [62:0] r;
    r = v;
    for (int i = 62; i >= 7; i--) begin
      if (r[i]) r = r ^ (63'h0C5 << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic [62:0] model_cw(input logic [55:0] m);
    return {m, rem63({m, 7'b0})};
  endfunction

  task automatic check(input string tag, input logic [62:0] obs, input logic [62:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present msg with start for one edge, push the expected codeword.
  task automatic start_encode(input logic [55:0] m);
    start = 1'b1;
    msg   = m;
    exp_q.push_back(model_cw(m));
    @(posedge clk);
    #1;
    start = 1'b0;
    msg   = {24'($urandom_range(0, 24'hFFFFFF)), 32'($urandom())};
    check("busy_after_start", 63'(busy), 63'(1'b1));
    check("state_after_start", 63'(dbg_state), 63'(SHIFT));
  endtask

  // Wait (bounded) for done, then score the codeword against the queue.
  task automatic wait_done(input string tag, input int exp_lat);
    int          lat;
    logic [62:0] exp_cw;
`ifdef BCH_ENC_SERIAL_OUT_EN
    logic [62:0] sbits;
    int          scnt;
    sbits = '0;
    scnt  = 0;
`endif
    lat = 0;
    while (!done && lat < exp_lat + 10) begin
      @(posedge clk);
      #1;
      lat++;
`ifdef BCH_ENC_SERIAL_OUT_EN
      if (ser_valid) begin
        sbits = {sbits[61:0], ser_bit};
        scnt++;
      end
`endif
    end
    check({tag, "_latency"}, 63'(lat), 63'(exp_lat));
    check({tag, "_busy_at_done"}, 63'(busy), 63'(1'b0));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 63'(1), 63'(0));
    end else begin
      exp_cw = exp_q.pop_front();
      check({tag, "_codeword"}, codeword, exp_cw);
`ifdef BCH_ENC_SERIAL_OUT_EN
      check({tag, "_ser_count"}, 63'(scnt), 63'(63));
      check({tag, "_ser_stream"}, sbits, exp_cw);
`endif
    end
  endtask

  // Stimulus: linear sequence of directed steps
  initial begin
    logic [55:0] m;
    logic [62:0] cw_hold;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    msg   = '0;

    // Reset state
    #1;
    check("rst_busy", 63'(busy), 63'(0));
    check("rst_done", 63'(done), 63'(0));
    check("rst_codeword", codeword, 63'h0);
    check("rst_state", 63'(dbg_state), 63'(IDLE));
`ifdef BCH_ENC_SERIAL_OUT_EN
    check("rst_ser_valid", 63'(ser_valid), 63'(0));
    check("rst_ser_bit", 63'(ser_bit), 63'(0));
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: all-zero message
    start_encode(56'h0);
    wait_done("msg0", LAT);
    check("msg0_const", codeword, 63'h0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 63'(done), 63'(0));

    // Directed: msg=1 (serial stream checked inside wait_done when built in)
    start_encode(56'h1);
    wait_done("msg1", LAT);
    check("msg1_const", codeword, 63'hC5);
    @(posedge clk);
    #1;

    // Directed: msg=2
    start_encode(56'h2);
    wait_done("msg2", LAT);
    check("msg2_const", codeword, 63'h14F);
    @(posedge clk);
    #1;

    // start during busy is ignored
    m = 56'hA5_5A12_3456_789A;
    start_encode(m);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    msg   = ~m;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_start_ignored", 63'(busy), 63'(1));
    wait_done("busy_ign", LAT - 11);

    // start during done is ignored, then accepted back-to-back
    cw_hold = codeword;
    start = 1'b1;
    msg   = 56'hFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_start_ignored", 63'(busy), 63'(0));
    check("done_cw_held", codeword, cw_hold);
    start_encode(56'h80_0000_0000_0001);
    wait_done("b2b", LAT);
    @(posedge clk);
    #1;

    // Reset mid-encode after 30 shifts
    start_encode(56'h12_3456_789A_BCDE);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_busy", 63'(busy), 63'(0));
    check("midrst_done", 63'(done), 63'(0));
    check("midrst_codeword", codeword, 63'h0);
    check("midrst_state", 63'(dbg_state), 63'(IDLE));
`ifdef BCH_ENC_SERIAL_OUT_EN
    check("midrst_ser_valid", 63'(ser_valid), 63'(0));
`endif
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", 63'(done), 63'(0));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_encode(56'h0F_EDCB_A987_6543);
    wait_done("post_rst", LAT);
    @(posedge clk);
    #1;

    // Random messages against the division model
    for (int i = 0; i < 1000; i++) begin
      m = {24'($urandom_range(0, 24'hFFFFFF)), 32'($urandom())};
      start_encode(m);
      wait_done("rand", LAT);
      check("rand_even_weight", 63'(^codeword), 63'(0));
      check("rand_syndrome", 63'(rem63(codeword)), 63'(0));
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
